// File: rtl/raster_pkg.sv
// Shared types for the raster stream receive path: tracker states, framing error codes
// and default frame geometry used for the coordinate index types.
package raster_pkg;
  localparam int INPUT_WIDTH      = 4;
  localparam int INPUT_HEIGHT     = 3;
  localparam int INPUT_WIDTH_LOG  = 2;
  localparam int INPUT_HEIGHT_LOG = 2;
  localparam int PIXEL_W          = 16;

  typedef enum logic [1:0] {IDLE, FRAME, DROP} state_t;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_NO_SOF    = 2'd1,
    ERR_EARLY_SOF = 2'd2,
    ERR_LINE_LEN  = 2'd3
  } err_t;

  typedef logic [INPUT_WIDTH_LOG-1:0]  x_idx_t;
  typedef logic [INPUT_HEIGHT_LOG-1:0] y_idx_t;
endpackage

// File: rtl/raster_stream_tracker_out_reg.sv
// Single-entry valid/ready pipeline register; refills in the same cycle it drains, so a
// continuous stream passes at full rate with one cycle of latency.
module stream_out_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_payload <= in_payload;
    end
  end
endmodule

// File: rtl/raster_stream_tracker.sv
// Receive-side raster tracker: rebuilds (x,y) for each pixel beat from SOF/EOL tags,
// checks framing, drops beats until the next SOF after an error, and registers the output.
module raster_stream_tracker
  import raster_pkg::*;
#(
  parameter int WIDTH  = INPUT_WIDTH,
  parameter int HEIGHT = INPUT_HEIGHT,
  parameter int X_W    = INPUT_WIDTH_LOG,
  parameter int Y_W    = INPUT_HEIGHT_LOG,
  parameter int DATA_W = PIXEL_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  input  logic              in_eol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [X_W-1:0]    out_x,
  output logic [Y_W-1:0]    out_y,
  output logic              out_first_col,
  output logic              out_last_col,
  output logic              out_last_pix,
  output logic              frame_done,
  output logic              err_pulse,
  output logic [1:0]        err_code,
  output state_t            tracker_state
);
  localparam int PW = DATA_W + X_W + Y_W + 3;
  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  // Handshake: a beat moves on either side only in a cycle where valid && ready are both
  // high; ready never depends on valid, and a held output beat stays frozen until taken.
  state_t         state_q, state_d;
  logic [X_W-1:0] x_q, x_d, pos_x;
  logic [Y_W-1:0] y_q, y_d, pos_y;
  logic           accept, fwd, done_d, last_col;
  err_t           err_d;
  logic [PW-1:0]  beat;

  assign accept        = in_valid && in_ready;
  assign tracker_state = state_q;
  assign last_col      = (pos_x == X_LAST);
  assign beat = {in_data, pos_x, pos_y, pos_x == '0, last_col, last_col && (pos_y == Y_LAST)};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    fwd     = 1'b0;
    done_d  = 1'b0;
    err_d   = ERR_NONE;
    pos_x   = in_sof ? '0 : x_q;
    pos_y   = in_sof ? '0 : y_q;
    if (accept) begin
      if (!in_sof && state_q != FRAME) begin
        state_d = DROP;
        x_d     = '0;
        y_d     = '0;
        if (state_q == IDLE) err_d = ERR_NO_SOF;
      end else begin
        fwd = 1'b1;
        if (in_sof && state_q == FRAME) err_d = ERR_EARLY_SOF;
        // A beat at the wrong place relative to EOL is still forwarded, then we resync.
        if (last_col != in_eol) begin
          state_d = DROP;
          x_d     = '0;
          y_d     = '0;
          if (err_d == ERR_NONE) err_d = ERR_LINE_LEN;
        end else if (last_col && pos_y == Y_LAST) begin
          state_d = IDLE;
          x_d     = '0;
          y_d     = '0;
          done_d  = 1'b1;
        end else if (last_col) begin
          state_d = FRAME;
          x_d     = '0;
          y_d     = pos_y + 1'b1;
        end else begin
          state_d = FRAME;
          x_d     = pos_x + 1'b1;
          y_d     = pos_y;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      frame_done <= 1'b0;
      err_pulse  <= 1'b0;
      err_code   <= 2'd0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      frame_done <= done_d;
      err_pulse  <= (err_d != ERR_NONE);
      err_code   <= err_d;
    end
  end

  logic [PW-1:0] out_payload;

  stream_out_reg #(.W(PW)) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (fwd),
    .in_ready    (in_ready),
    .in_payload  (beat),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_payload (out_payload)
  );

  assign {out_data, out_x, out_y, out_first_col, out_last_col, out_last_pix} = out_payload;
endmodule

// File: tb/tb_raster_stream_tracker.sv
// Bench for raster_stream_tracker at WIDTH=4, HEIGHT=3: scoreboard of forwarded beats
// and of pulses, filled by the drivers and drained by a negedge monitor.
module tb_raster_stream_tracker;
  import raster_pkg::*;

  localparam int WIDTH  = 4;
  localparam int HEIGHT = 3;
  localparam int X_W    = 2;
  localparam int Y_W    = 2;
  localparam int DATA_W = 16;
  localparam int PW     = DATA_W + X_W + Y_W + 3;
  localparam logic [3:0] P_DONE  = 4'b1000;
  localparam logic [3:0] P_NOSOF = 4'b0101;
  localparam logic [3:0] P_EARLY = 4'b0110;
  localparam logic [3:0] P_LEN   = 4'b0111;

  logic              clock = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, in_sof, in_eol;
  logic [DATA_W-1:0] in_data;
  logic              out_valid, out_ready;
  logic [DATA_W-1:0] out_data;
  logic [X_W-1:0]    out_x;
  logic [Y_W-1:0]    out_y;
  logic              out_first_col, out_last_col, out_last_pix;
  logic              frame_done, err_pulse;
  logic [1:0]        err_code;
  state_t            tracker_state;

  raster_stream_tracker #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W), .DATA_W(DATA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_eol(in_eol),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_x(out_x), .out_y(out_y),
    .out_first_col(out_first_col), .out_last_col(out_last_col), .out_last_pix(out_last_pix),
    .frame_done(frame_done), .err_pulse(err_pulse), .err_code(err_code),
    .tracker_state(tracker_state)
  );

  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;
  logic [PW-1:0] exp_q[$];
  logic [3:0]    pulse_q[$];
  logic [PW-1:0] cur, held, e;
  logic [3:0]    ep;
  bit            stalled_prev = 1'b0;

  assign cur = {out_data, out_x, out_y, out_first_col, out_last_col, out_last_pix};

  function automatic logic [PW-1:0] pack(input logic [DATA_W-1:0] d, input x_idx_t x,
                                         input y_idx_t y);
    pack = {d, x, y, x == 2'd0, x == 2'd3, (x == 2'd3) && (y == 2'd2)};
  endfunction

  // Monitor: every beat taken downstream and every pulse is matched against the queues.
  always @(negedge clock) begin
    if (reset) begin
      stalled_prev = 1'b0;
    end else begin
      if (stalled_prev) begin
        compared++;
        if (!out_valid || cur !== held) begin
          mismatched++;
          $display("FAIL hold: valid=%0b beat=%h, required valid=1 beat=%h", out_valid, cur, held);
        end
      end
      stalled_prev = out_valid && !out_ready;
      held = cur;
      if (out_valid && out_ready) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL beat: unexpected beat %h (x=%0d y=%0d)", cur, out_x, out_y);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e) begin
            mismatched++;
            $display("FAIL beat: got %h (x=%0d y=%0d), required %h", cur, out_x, out_y, e);
          end
        end
      end
      if (frame_done || err_pulse) begin
        compared++;
        if (pulse_q.size() == 0) begin
          mismatched++;
          $display("FAIL pulse: unexpected done=%0b err=%0b code=%0d", frame_done, err_pulse,
                   err_code);
        end else begin
          ep = pulse_q.pop_front();
          if ({frame_done, err_pulse, err_code} !== ep) begin
            mismatched++;
            $display("FAIL pulse: got %b, required %b", {frame_done, err_pulse, err_code}, ep);
          end
        end
      end
    end
  end

  task automatic send_beat(input logic sof, input logic eol, input bit fwd, input x_idx_t x,
                           input y_idx_t y, input logic [3:0] pulse);
    logic [DATA_W-1:0] d;
    logic rdy;
    int cyc;
    d = DATA_W'($urandom_range(0, 65535));
    in_valid = 1'b1;
    in_data  = d;
    in_sof   = sof;
    in_eol   = eol;
    cyc = 0;
    do begin
      @(negedge clock);
      rdy = in_ready;
      @(posedge clock);
      #1;
      cyc++;
    end while (!rdy && cyc < 100);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_eol   = 1'b0;
    if (!rdy) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: in_ready=0 for %0d cycles, required 1", cyc);
    end
    if (fwd) exp_q.push_back(pack(d, x, y));
    if (pulse != 4'b0000) pulse_q.push_back(pulse);
  endtask

  task automatic send_frame();
    x_idx_t x;
    y_idx_t y;
    for (int i = 0; i < WIDTH * HEIGHT; i++) begin
      x = X_W'(i % WIDTH);
      y = Y_W'(i / WIDTH);
      send_beat(i == 0, x == 2'd3, 1'b1, x, y, (i == WIDTH * HEIGHT - 1) ? P_DONE : 4'b0000);
    end
  endtask

  task automatic drain(input string name);
    repeat (4) @(posedge clock);
    #1;
    compared++;
    if (exp_q.size() != 0 || pulse_q.size() != 0) begin
      mismatched++;
      $display("FAIL %s_drain: %0d beats and %0d pulses outstanding, required 0 and 0", name,
               exp_q.size(), pulse_q.size());
    end
    exp_q.delete();
    pulse_q.delete();
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_sof    = 1'b0;
    in_eol    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    compared++;
    if (out_valid !== 1'b0 || frame_done !== 1'b0 || err_pulse !== 1'b0 || err_code !== 2'd0 ||
        cur !== '0 || tracker_state !== IDLE || in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset: valid=%0b done=%0b err=%0b code=%0d beat=%h state=%0d ready=%0b, required all 0 and ready=1",
               out_valid, frame_done, err_pulse, err_code, cur, tracker_state, in_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_no_sof();
    for (int i = 0; i < 3; i++) send_beat(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, (i == 0) ? P_NOSOF : 4'b0000);
    send_frame();
    drain("no_sof");
  endtask

  task automatic test_clean_frame();
    send_frame();
    drain("clean_frame");
  endtask

  task automatic test_back_pressure();
    bit bp_done;
    bp_done = 1'b0;
    fork
      begin
        send_frame();
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clock);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    drain("back_pressure");
  endtask

  task automatic test_short_line();
    send_beat(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, 4'b0000);
    send_beat(1'b0, 1'b0, 1'b1, 2'd1, 2'd0, 4'b0000);
    send_beat(1'b0, 1'b1, 1'b1, 2'd2, 2'd0, P_LEN);
    send_beat(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 4'b0000);
    send_beat(1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'b0000);
    send_frame();
    drain("short_line");
  endtask

  task automatic test_early_sof();
    x_idx_t x;
    y_idx_t y;
    for (int i = 0; i < 5; i++) begin
      x = X_W'(i % WIDTH);
      y = Y_W'(i / WIDTH);
      send_beat(i == 0, x == 2'd3, 1'b1, x, y, 4'b0000);
    end
    send_beat(1'b1, 1'b0, 1'b1, 2'd0, 2'd0, P_EARLY);
    for (int j = 1; j < WIDTH * HEIGHT; j++) begin
      x = X_W'(j % WIDTH);
      y = Y_W'(j / WIDTH);
      send_beat(1'b0, x == 2'd3, 1'b1, x, y, (j == WIDTH * HEIGHT - 1) ? P_DONE : 4'b0000);
    end
    drain("early_sof");
  endtask

  task automatic test_reset_mid_frame();
    x_idx_t x;
    y_idx_t y;
    for (int i = 0; i < 7; i++) begin
      x = X_W'(i % WIDTH);
      y = Y_W'(i / WIDTH);
      send_beat(i == 0, x == 2'd3, 1'b1, x, y, 4'b0000);
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_frame_valid: out_valid=%0b, required 1", out_valid);
    end
    out_ready = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    compared++;
    if (out_valid !== 1'b0 || tracker_state !== IDLE) begin
      mismatched++;
      $display("FAIL mid_frame_reset: valid=%0b state=%0d, required 0 and IDLE", out_valid,
               tracker_state);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    send_frame();
    drain("reset_mid_frame");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_no_sof();
    test_clean_frame();
    test_back_pressure();
    test_short_line();
    test_early_sof();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
